// File: rtl/sap_prog_loader_if.sv
// Host word stream and SRAM port of the SAP-1 program loader.
// master is the loader side; slave is the host/SRAM side.
interface sap_prog_loader_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 9
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we_n;
    logic          mem_ce_n;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  in_valid, in_data, mem_rdata,
        output in_ready, mem_addr, mem_wdata, mem_we_n, mem_ce_n
    );

    modport slave (
        output in_valid, in_data, mem_rdata,
        input  in_ready, mem_addr, mem_wdata, mem_we_n, mem_ce_n
    );
endinterface

// File: rtl/sap_prog_loader.sv
// Loads the SAP-1 SRAM from a host stream, checks the checksum, reads the
// memory back to verify it, and only then releases the CPU from reset.
module sap_prog_loader #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    sap_prog_loader_if.master bus,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);
    // One extra count value marks "all words read, compare pending".
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LastIdx = CW'(DEPTH - 1);
    localparam logic [CW-1:0] AllRead = CW'(DEPTH);

    typedef enum logic [2:0] {StIdle, StLoad, StCheck, StVerify, StDone, StError} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] load_sum_q, load_sum_d;
    logic [DW-1:0] rd_sum_q, rd_sum_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_n_q, we_n_d;
    logic          ce_n_q, ce_n_d;
    logic [1:0]    err_q, err_d;
    logic          in_ready;
    logic          accept;

    assign in_ready = (state_q == StLoad) || (state_q == StCheck);
    assign accept   = bus.in_valid & in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we_n  = we_n_q;
    assign bus.mem_ce_n  = ce_n_q;

    assign busy     = (state_q == StLoad) || (state_q == StCheck) || (state_q == StVerify);
    assign done     = (state_q == StDone);
    assign error    = (state_q == StError);
    assign cpu_rst  = (state_q != StDone);
    assign err_code = err_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        load_sum_d = load_sum_q;
        rd_sum_d   = rd_sum_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_n_d     = 1'b1;
        ce_n_d     = 1'b1;
        err_d      = err_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d    = StLoad;
                    count_d    = '0;
                    load_sum_d = '0;
                    rd_sum_d   = '0;
                    err_d      = 2'b00;
                end
            end
            StLoad: begin
                if (accept) begin
                    addr_d     = AW'(count_q);
                    wdata_d    = bus.in_data;
                    we_n_d     = 1'b0;
                    count_d    = count_q + 1'b1;
                    load_sum_d = load_sum_q + bus.in_data;
                    if (count_q == LastIdx) state_d = StCheck;
                end
            end
            StCheck: begin
                if (accept) begin
                    if (bus.in_data == load_sum_q) begin
                        state_d  = StVerify;
                        count_d  = '0;
                        rd_sum_d = '0;
                        addr_d   = '0;
                        ce_n_d   = 1'b0;
                    end else begin
                        state_d = StError;
                        err_d   = 2'b01;
                    end
                end
            end
            StVerify: begin
                if (count_q == AllRead) begin
                    if (rd_sum_q == load_sum_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StError;
                        err_d   = 2'b10;
                    end
                end else begin
                    // Read data is combinational, so it is summed at the end of its own cycle.
                    rd_sum_d = rd_sum_q + bus.mem_rdata;
                    count_d  = count_q + 1'b1;
                    if (count_q != LastIdx) begin
                        addr_d = AW'(count_q + 1'b1);
                        ce_n_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            load_sum_q <= '0;
            rd_sum_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_n_q     <= 1'b1;
            ce_n_q     <= 1'b1;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            load_sum_q <= load_sum_d;
            rd_sum_q   <= rd_sum_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_n_q     <= we_n_d;
            ce_n_q     <= ce_n_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: doc/sap_prog_loader.md
Name: sap_prog_loader

Overview:
Program loader that writes the SAP-1 program/data SRAM, which the CPU only reads. A host streams 9-bit words over a valid/ready handshake, and the block writes them to consecutive SRAM addresses from 0. It then checks a host-supplied checksum, reads the whole memory back to verify it, and only then releases the CPU from reset. It sits between the host/debug port and the SRAM write port, and drives the CPU reset line.

Parameters:
DEPTH, 16, number of SRAM words loaded and verified (addresses 0..DEPTH-1)
AW, 5, SRAM address width
DW, 9, SRAM word width; also the checksum width

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR
in_valid  input  1  host word valid
in_data  input  DW  host word: DEPTH program words, then 1 checksum word
in_ready  output  1  block accepts in_data this cycle when in_valid=1
mem_addr  output  AW  SRAM address, registered
mem_wdata  output  DW  SRAM write data, registered
mem_we_n  output  1  active-low SRAM write strobe, registered; SRAM captures on the edge ending a low cycle
mem_ce_n  output  1  active-low SRAM read enable, registered; combinational read data is returned in the same cycle
mem_rdata  input  DW  SRAM read data
cpu_rst  output  1  active-high reset/hold to the CPU
busy  output  1  high in LOAD, CHECK and VERIFY
done  output  1  load and verify passed
error  output  1  load failed
err_code  output  2  00 none; 01 checksum mismatch; 10 readback mismatch

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. All outputs are forced to these values on the next cycle: in_ready=0, mem_addr=0, mem_wdata=0, mem_we_n=1, mem_ce_n=1, cpu_rst=1, busy=0, done=0, error=0, err_code=00. The word counter and both running sums clear.
- Reset mid-operation: a pending write pulse is cancelled (mem_we_n=1 in the next cycle). There is no partial completion.
- cpu_rst=1 in every state except DONE.
- Sums: load_sum and rd_sum are DW bits wide, modulo 2^DW. Accepted checksum words are never added to either sum.
- FSM states: IDLE, LOAD, CHECK, VERIFY, DONE, ERROR.
- IDLE: in_ready=0. start=1 -> LOAD; the counter and sums clear.
- LOAD:
  - in_ready=1, so one word per cycle is possible.
  - Accept = in_valid & in_ready.
  - On an accept at edge N, during cycle N+1: mem_addr=count, mem_wdata=in_data, mem_we_n=0. The count increments and load_sum += in_data.
  - Cycles with no accept have mem_we_n=1, and addresses stay contiguous.
  - The DEPTH-th accept -> CHECK.
- CHECK:
  - in_ready=1. The final write pulse occurs in the first CHECK cycle.
  - On accept: in_data==load_sum -> VERIFY; otherwise -> ERROR with err_code=01.
- VERIFY:
  - in_ready=0, mem_we_n=1, mem_ce_n=0.
  - Cycle k (k=0..DEPTH-1) drives mem_addr=k, and mem_rdata is sampled at the end of that cycle into rd_sum.
  - After DEPTH reads: rd_sum==load_sum -> DONE; otherwise -> ERROR with err_code=10.
  - mem_ce_n returns to 1 on exit.
- DONE: done=1, cpu_rst=0, busy=0. Held until start or rst.
- ERROR: error=1 and err_code are held; cpu_rst=1. Held until start or rst.
- start in LOAD, CHECK or VERIFY is ignored. start in DONE or ERROR restarts: LOAD in the next cycle with done/error/err_code cleared and cpu_rst=1.
- Latency: with in_valid held high, done rises 1+DEPTH+1+DEPTH=34 cycles after the edge that samples start (DEPTH=16).
- mem_we_n and mem_ce_n are never low in the same cycle.

Test Plan:
1. Nominal load. Stream 0x009,0x02A,0x04B,0x060, 0x1FF x5, 0x001,0x002,0x001, 0x1FF x4, then checksum 0x0D9, with in_valid always high -> 16 write pulses at addr 0..15 with matching data, 16 reads, done=1, cpu_rst=0 exactly 34 cycles after start, err_code=00.
2. Same stream with checksum 0x0DA -> error=1, err_code=01, mem_ce_n never low, cpu_rst stays 1.
3. Same stream as scenario 1, with the memory model returning 0x003 at addr 9 during VERIFY -> error=1, err_code=10 after exactly 16 read cycles.
4. in_valid high only on alternate cycles -> writes only follow accepts, addresses stay contiguous 0..15, done=1, and the SRAM contents equal the scenario 1 data.
5. rst=1 for one cycle after 5 accepted words -> next cycle all outputs at reset values with mem_we_n=1. A fresh start plus the full scenario 1 stream then reaches done=1.
6. start pulsed during LOAD -> no effect, addresses continue. start pulsed in DONE -> next cycle done=0, cpu_rst=1, busy=1, in_ready=1, and the next write goes to addr 0.
